// File: rtl/rprelu_channel_serializer.sv
// Captures a CHANNEL_NUM-wide rprelu vector and streams it out as LANES-wide beats under valid/ready.
// Optional: define RPRELU_SER_OVF_CNT_EN to add a saturating dropped-vector counter (ovf_cnt).
module rprelu_channel_serializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int LANES       = 16,
    localparam int GROUPS     = CHANNEL_NUM / LANES,
    localparam int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in [CHANNEL_NUM],
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data [LANES],
    output logic [GW-1:0]         out_group,
    output logic                  out_last,
    output logic                  overflow
`ifdef RPRELU_SER_OVF_CNT_EN
    ,
    output logic [15:0]           ovf_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (CHANNEL_NUM % LANES != 0) begin : g_bad_lanes
        $error("CHANNEL_NUM (%0d) must be a multiple of LANES (%0d)", CHANNEL_NUM, LANES);
    end

    logic [0:0]            state;
    logic [GW-1:0]         group;
    logic [DATA_WIDTH-1:0] buf_q   [GROUPS][LANES];
    logic [DATA_WIDTH-1:0] in_grp  [GROUPS][LANES];
    logic                  capture;
    logic                  transfer;
    logic                  drop;

    // Regroup the flat input so channel c lands in beat c/LANES, lane c%LANES.
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign in_grp[g][l] = data_in[g*LANES + l];
        end
    end

    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (group == GW'(GROUPS - 1));
    assign out_group = group;
    assign out_data  = buf_q[group];

    assign in_ready  = (state == IDLE) | ((state == SEND) & out_last & out_ready);
    assign capture   = data_in_valid & in_ready;
    assign drop      = data_in_valid & ~in_ready;
    assign transfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            group    <= '0;
            overflow <= 1'b0;
            // NOTE: the capture buffer is reset so out_data reads zero after reset; it is a register array, not a RAM.
            buf_q    <= '{default: '{default: '0}};
        end else begin
            if (capture) begin
                buf_q <= in_grp;
                state <= SEND;
                group <= '0;
            end else if (transfer) begin
                if (out_last) begin
                    state <= IDLE;
                    group <= '0;
                end else begin
                    group <= group + GW'(1);
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RPRELU_SER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
